sm3_msg_expnd: RTL and testbench
================================

Name: sm3_msg_expnd

Overview:
- Sits directly downstream of the SM3 padding stage, which emits 32-bit padded words.
- Collects one 512-bit block (16 words) into a 16-entry word window.
- Then emits the SM3 message expansion one round per cycle to the compression stage: W_j and W'_j for j = 0..63.
- Exerts block-level back-pressure on the padder through blk_rdy_o, which drives the padder's output-enable input.

Parameters:
- WD_W, 32, word width in bits; this block supports 32 only.
- BLK_WD_NUM, 16, words per 512-bit block.
- RND_NUM, 64, compression rounds per block.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pad_d_i  in  32  padded word from the padder
- pad_vld_i  in  1  pad_d_i valid; no stall is possible on this interface
- pad_lst_i  in  1  last word of the last block of the message
- blk_rdy_o  out  1  window can accept words; connects to the padder's output-enable
- exp_w_o  out  32  W_j
- exp_wp_o  out  32  W'_j = W_j ^ W_{j+4}
- exp_rnd_o  out  6  round index j
- exp_vld_o  out  1  expansion output valid
- exp_lst_o  out  1  round 63 of the message's last block
- exp_rdy_i  in  1  compression stage accepts the current round
- ovf_err_o  out  1  sticky: a word arrived while not loading

Behaviour:
- Reset: reset is rst_n, asynchronous, active-low; clock is clk.
  - State = LOAD, wd_cnt = 0, window = 0, lst_flg = 0, rnd = 0.
  - Outputs at reset: blk_rdy_o = 1; exp_vld_o, exp_lst_o and ovf_err_o = 0; exp_w_o, exp_wp_o and exp_rnd_o = 0.
- State LOAD:
  - Each pad_vld_i shifts pad_d_i into window slot wd_cnt and increments the 4-bit wd_cnt.
  - pad_lst_i together with pad_vld_i sets lst_flg.
  - blk_rdy_o = (state == LOAD) && (wd_cnt != 15). It drops one word early because the padder has a one-cycle input register and may still deliver one word after seeing ready.
  - When the 16th word is accepted (wd_cnt == 15 && pad_vld_i): go to EXPD, set wd_cnt = 0 and rnd = 0.
- State EXPD:
  - Window holds W_j..W_{j+15}, with slot 0 = W_j.
  - Combinational outputs: exp_vld_o = 1, exp_w_o = slot0, exp_wp_o = slot0 ^ slot4, exp_rnd_o = rnd.
  - On exp_vld_o && exp_rdy_i: shift the window down by one, load slot15 with W_{j+16}, and increment rnd.
  - W_{j+16} = P1(slot0 ^ slot7 ^ ROL(slot13,15)) ^ ROL(slot3,7) ^ slot10, where P1(x) = x ^ ROL(x,15) ^ ROL(x,23).
  - W_64..W_67 are computed but never emitted (they are only needed for W'_60..63).
  - exp_lst_o = lst_flg && rnd == 63.
  - When exp_rdy_i is low, all outputs and state hold; the window does not shift.
  - When round 63 is accepted: go to LOAD and clear lst_flg if it was set.
- Latency: the first round (j = 0) is valid in the cycle after the 16th word is accepted. With exp_rdy_i held high, one block takes 16 load cycles plus 64 expansion cycles.
- Boundary conditions:
  - pad_vld_i while in EXPD: the word is dropped, ovf_err_o is set (sticky until reset), and the window is not disturbed.
  - pad_lst_i arriving before wd_cnt == 15: not flagged. The padder guarantees block alignment, so the block is simply not complete yet.
  - Simultaneous round-63 accept and pad_vld_i: the word counts as overflow, because the state is still EXPD in that cycle.
  - The rnd counter wraps at 64 but is always cleared on entry to EXPD.
  - Reset asserted mid-block returns to the reset state immediately; partial data is discarded.

Decomposition:
- Shared sm3 package/include holds: WD_W, BLK_WD_NUM, RND_NUM, the state encodings (LOAD, EXPD), and the ROL / P1 function definitions. P0 is also placed there for use by the compression stage.
- One natural sub-module, sm3_w_gen: purely combinational; inputs are slots 0, 3, 7, 10 and 13; output is W_{j+16}.
- The FSM, counters and window stay in sm3_msg_expnd.

Test Plan:
- Message "abc": load words 61626380, 0 x 14, 00000018 with pad_lst_i on the final word, exp_rdy_i = 1.
  - Round 0: exp_w_o = 61626380, exp_wp_o = 61626380.
  - Round 16 (after 16 accepts): exp_w_o = 9092e200.
  - exp_lst_o is asserted exactly at rnd = 63.
  - blk_rdy_o then returns to 1.
- Ready timing: drive 16 back-to-back words.
  - blk_rdy_o = 1 up to and including the cycle where the 15th word arrives; 0 from the next cycle (wd_cnt = 15) onward.
  - exp_vld_o rises one cycle after the 16th word.
- Stall: toggle exp_rdy_i randomly.
  - exp_rnd_o and exp_w_o hold while exp_rdy_i = 0.
  - The sequence of 64 words matches a software model; no round is lost or duplicated.
- Two-block message: the last-block flag is present on block 2 only.
  - exp_lst_o = 0 throughout block 1 and pulses once at block 2, round 63.
- Overflow: pulse pad_vld_i with value deadbeef during EXPD round 10.
  - ovf_err_o = 1 and stays sticky.
  - Round 10..63 outputs are unchanged versus the clean run.
- Reset mid-EXPD at round 30:
  - exp_vld_o = 0 and blk_rdy_o = 1 immediately.
  - A following "abc" block reproduces scenario 1 exactly.

Source files
------------

// File: rtl/sm3_pkg.sv
// Shared SM3 definitions: sizes, expander state encoding and the rotate /
// permutation helpers used by the expander and the compression stage.
package sm3_pkg;

    localparam int WD_W       = 32;
    localparam int BLK_WD_NUM = 16;
    localparam int RND_NUM    = 64;

    typedef enum logic {
        LOAD = 1'b0,
        EXPD = 1'b1
    } state_t;

    function automatic logic [WD_W-1:0] rol(input logic [WD_W-1:0] x, input int unsigned n);
        return (x << n) | (x >> (WD_W - n));
    endfunction

    // P0 belongs to the compression stage; it lives here so both share one copy.
    function automatic logic [WD_W-1:0] p0(input logic [WD_W-1:0] x);
        return x ^ rol(x, 9) ^ rol(x, 17);
    endfunction

    function automatic logic [WD_W-1:0] p1(input logic [WD_W-1:0] x);
        return x ^ rol(x, 15) ^ rol(x, 23);
    endfunction

endpackage

// File: rtl/sm3_w_gen.sv
// Next-word generator: W_{j+16} from the window slots 0, 3, 7, 10 and 13.
module sm3_w_gen
    import sm3_pkg::*;
(
    input  logic [WD_W-1:0] s0,
    input  logic [WD_W-1:0] s3,
    input  logic [WD_W-1:0] s7,
    input  logic [WD_W-1:0] s10,
    input  logic [WD_W-1:0] s13,
    output logic [WD_W-1:0] w_nxt
);

    assign w_nxt = p1(s0 ^ s7 ^ rol(s13, 15)) ^ rol(s3, 7) ^ s10;

endmodule

// File: rtl/sm3_msg_expnd.sv
// SM3 message expander: gathers a 16-word block from the padder, then streams
// W_j / W'_j for rounds 0..63 to the compression stage, one per accepted cycle.
module sm3_msg_expnd
    import sm3_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [WD_W-1:0] pad_d_i,
    input  logic            pad_vld_i,
    input  logic            pad_lst_i,
    output logic            blk_rdy_o,
    output logic [WD_W-1:0] exp_w_o,
    output logic [WD_W-1:0] exp_wp_o,
    output logic [5:0]      exp_rnd_o,
    output logic            exp_vld_o,
    output logic            exp_lst_o,
    input  logic            exp_rdy_i,
    output logic            ovf_err_o
);

    state_t          state;
    logic [3:0]      wd_cnt;
    logic [5:0]      rnd;
    logic            lst_flg;
    logic            ovf;
    logic [WD_W-1:0] win [BLK_WD_NUM];
    logic [WD_W-1:0] w_nxt;
    logic            expd;

    assign expd = (state == EXPD);

    sm3_w_gen u_w_gen (
        .s0    (win[0]),
        .s3    (win[3]),
        .s7    (win[7]),
        .s10   (win[10]),
        .s13   (win[13]),
        .w_nxt (w_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= LOAD;
            wd_cnt  <= '0;
            rnd     <= '0;
            lst_flg <= 1'b0;
            ovf     <= 1'b0;
            for (int i = 0; i < BLK_WD_NUM; i++) win[i] <= '0;
        end else begin
            // The padder cannot stall, so a word arriving mid-expansion is lost.
            if (pad_vld_i && expd) ovf <= 1'b1;

            if (state == LOAD) begin
                if (pad_vld_i) begin
                    win[wd_cnt] <= pad_d_i;
                    wd_cnt      <= wd_cnt + 4'd1;
                    if (pad_lst_i) lst_flg <= 1'b1;
                    if (wd_cnt == 4'd15) begin
                        state <= EXPD;
                        rnd   <= '0;
                    end
                end
            end else if (exp_rdy_i) begin
                for (int i = 0; i < BLK_WD_NUM - 1; i++) win[i] <= win[i+1];
                win[BLK_WD_NUM-1] <= w_nxt;
                rnd               <= rnd + 6'd1;
                if (rnd == 6'(RND_NUM - 1)) begin
                    state   <= LOAD;
                    lst_flg <= 1'b0;
                end
            end
        end
    end

    // Ready drops one word early: the padder's input register may still hold
    // one word in flight after it last saw ready.
    assign blk_rdy_o = (state == LOAD) && (wd_cnt != 4'd15);
    assign exp_vld_o = expd;
    assign exp_w_o   = expd ? win[0] : '0;
    assign exp_wp_o  = expd ? (win[0] ^ win[4]) : '0;
    assign exp_rnd_o = rnd;
    assign exp_lst_o = expd && lst_flg && (rnd == 6'(RND_NUM - 1));
    assign ovf_err_o = ovf;

endmodule

// File: tb/tb_sm3_msg_expnd.sv
// Directed bench for sm3_msg_expnd: "abc" block, ready timing, stalls,
// two-block message, overflow and mid-block reset, against a reference expansion.
module tb_sm3_msg_expnd;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pad_d = '0;
    logic        pad_vld = 1'b0;
    logic        pad_lst = 1'b0;
    logic        blk_rdy;
    logic [31:0] exp_w;
    logic [31:0] exp_wp;
    logic [5:0]  exp_rnd;
    logic        exp_vld;
    logic        exp_lst;
    logic        exp_rdy = 1'b1;
    logic        ovf_err;

    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] wm  [68];
    logic [31:0] blk [16];

    always #5 clk = ~clk;

    sm3_msg_expnd dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pad_d_i   (pad_d),
        .pad_vld_i (pad_vld),
        .pad_lst_i (pad_lst),
        .blk_rdy_o (blk_rdy),
        .exp_w_o   (exp_w),
        .exp_wp_o  (exp_wp),
        .exp_rnd_o (exp_rnd),
        .exp_vld_o (exp_vld),
        .exp_lst_o (exp_lst),
        .exp_rdy_i (exp_rdy),
        .ovf_err_o (ovf_err)
    );

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] pp1(input logic [31:0] x);
        return x ^ rl(x, 15) ^ rl(x, 23);
    endfunction

    // Reference expansion in its textbook indexed form.
    task automatic model();
        for (int j = 0; j < 16; j++) wm[j] = blk[j];
        for (int j = 16; j < 68; j++)
            wm[j] = pp1(wm[j-16] ^ wm[j-9] ^ rl(wm[j-3], 15)) ^ rl(wm[j-13], 7) ^ wm[j-6];
    endtask

    task automatic set_abc();
        blk[0] = 32'h61626380;
        for (int i = 1; i < 15; i++) blk[i] = 32'h0;
        blk[15] = 32'h00000018;
        model();
    endtask

    task automatic set_pat(input logic [31:0] seed);
        for (int i = 0; i < 16; i++) blk[i] = seed * 32'(i + 1) ^ {seed[15:0], seed[31:16]};
        model();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load(input bit lst, input bit chk_rdy);
        for (int i = 0; i < 16; i++) begin
            if (chk_rdy) chk($sformatf("blk_rdy wd%0d", i), 32'(blk_rdy), 32'(i != 15));
            pad_vld = 1'b1;
            pad_d   = blk[i];
            pad_lst = lst && (i == 15);
            @(negedge clk);
        end
        pad_vld = 1'b0;
        pad_lst = 1'b0;
        if (chk_rdy) chk("vld after 16th", 32'(exp_vld), 32'd1);
    endtask

    task automatic run(input int from, input int to, input bit lst, input bit stall, input int ovf_at);
        int j = from;
        int budget = 0;
        bit inj = 1'b0;
        while (j < to && budget < 2000) begin
            budget++;
            chk($sformatf("r%0d vld", j), 32'(exp_vld), 32'd1);
            chk($sformatf("r%0d rnd", j), 32'(exp_rnd), 32'(j));
            chk($sformatf("r%0d w", j), exp_w, wm[j]);
            chk($sformatf("r%0d wp", j), exp_wp, wm[j] ^ wm[j+4]);
            chk($sformatf("r%0d lst", j), 32'(exp_lst), 32'(lst && j == 63));
            exp_rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (j == ovf_at && !inj) begin
                pad_vld = 1'b1;
                pad_d   = 32'hdeadbeef;
                inj     = 1'b1;
            end
            @(negedge clk);
            pad_vld = 1'b0;
            if (exp_rdy) j++;
        end
        exp_rdy = 1'b1;
        if (j < to) begin
            nvec++;
            nerr++;
            $error("FAIL run timeout: reached round %0d expected %0d", j, to);
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst blk_rdy", 32'(blk_rdy), 32'd1);
        chk("rst vld", 32'(exp_vld), 32'd0);
        chk("rst lst", 32'(exp_lst), 32'd0);
        chk("rst ovf", 32'(ovf_err), 32'd0);
        chk("rst w", exp_w, 32'h0);
        chk("rst wp", exp_wp, 32'h0);
        chk("rst rnd", 32'(exp_rnd), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // "abc" single block, with ready timing during the load
        set_abc();
        load(1'b1, 1'b1);
        chk("abc w0", exp_w, 32'h61626380);
        chk("abc wp0", exp_wp, 32'h61626380);
        run(0, 16, 1'b1, 1'b0, -1);
        chk("abc w16", exp_w, 32'h9092e200);
        run(16, 64, 1'b1, 1'b0, -1);
        chk("abc end blk_rdy", 32'(blk_rdy), 32'd1);
        chk("abc end vld", 32'(exp_vld), 32'd0);
        chk("abc end lst", 32'(exp_lst), 32'd0);

        // Random back-pressure on a non-trivial block
        set_pat(32'h9e3779b9);
        load(1'b1, 1'b0);
        run(0, 64, 1'b1, 1'b1, -1);

        // Two-block message: last flag only on the second block
        set_pat(32'h01234567);
        load(1'b0, 1'b0);
        run(0, 64, 1'b0, 1'b0, -1);
        set_pat(32'hcafef00d);
        load(1'b1, 1'b0);
        run(0, 64, 1'b1, 1'b0, -1);

        // Overflow word during round 10 must not disturb the stream
        set_abc();
        load(1'b1, 1'b0);
        chk("ovf before", 32'(ovf_err), 32'd0);
        run(0, 64, 1'b1, 1'b0, 10);
        chk("ovf set", 32'(ovf_err), 32'd1);
        load(1'b0, 1'b0);
        chk("ovf sticky", 32'(ovf_err), 32'd1);
        run(0, 30, 1'b0, 1'b0, -1);

        // Asynchronous reset at round 30
        rst_n = 1'b0;
        #1;
        chk("mid rst vld", 32'(exp_vld), 32'd0);
        chk("mid rst blk_rdy", 32'(blk_rdy), 32'd1);
        chk("mid rst ovf", 32'(ovf_err), 32'd0);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        load(1'b1, 1'b1);
        chk("re-abc w0", exp_w, 32'h61626380);
        run(0, 16, 1'b1, 1'b0, -1);
        chk("re-abc w16", exp_w, 32'h9092e200);
        run(16, 64, 1'b1, 1'b0, -1);
        chk("re-abc end blk_rdy", 32'(blk_rdy), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
